// File: rtl/program_load_controller.sv
// Framed program loader: parses UART bytes into instruction-memory writes,
// zero-fills unused words and releases the CPU only after a checksum-correct image.
`timescale 1ns/1ps
module program_load_controller #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              start_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              cpu_run_o,
  output logic              load_done_o,
  output logic              load_error_o
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CMP_W = (IDX_W > 8) ? IDX_W : 8;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [CMP_W-1:0] DEPTH_CMP = CMP_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_WAIT_SYNC,
    S_GET_LEN,
    S_GET_HI,
    S_GET_LO,
    S_GET_CSUM,
    S_FILL,
    S_DONE,
    S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         hi_q, hi_d;
  logic [7:0]         xor_q, xor_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic               run_q, run_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [IDX_W-1:0]   idx_inc;
  logic [TMO_W-1:0]   tmo_inc;
  logic               in_frame;

  assign idx_inc  = idx_q + 1'b1;
  assign tmo_inc  = tmo_q + 1'b1;
  assign in_frame = (state_q == S_GET_LEN) || (state_q == S_GET_HI) ||
                    (state_q == S_GET_LO)  || (state_q == S_GET_CSUM);

  // Next-state and registered-output decode; start overrides everything.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    xor_d   = xor_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (start_i) begin
      state_d = S_WAIT_SYNC;
      idx_d   = '0;
      xor_d   = '0;
    end else begin
      unique case (state_q)
        S_WAIT_SYNC: begin
          if (rx_valid_i && (rx_data_i == SYNC_BYTE)) state_d = S_GET_LEN;
        end
        S_GET_LEN: begin
          if (rx_valid_i) begin
            if ((rx_data_i == 8'h00) || (CMP_W'(rx_data_i) > DEPTH_CMP)) begin
              state_d = S_ERROR;
            end else begin
              len_d   = IDX_W'(rx_data_i);
              idx_d   = '0;
              xor_d   = '0;
              state_d = S_GET_HI;
            end
          end
        end
        S_GET_HI: begin
          if (rx_valid_i) begin
            hi_d    = rx_data_i;
            xor_d   = xor_q ^ rx_data_i;
            state_d = S_GET_LO;
          end
        end
        S_GET_LO: begin
          if (rx_valid_i) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = {hi_q, rx_data_i};
            xor_d   = xor_q ^ rx_data_i;
            idx_d   = idx_inc;
            state_d = (idx_inc == len_q) ? S_GET_CSUM : S_GET_HI;
          end
        end
        S_GET_CSUM: begin
          if (rx_valid_i) begin
            if (rx_data_i != xor_q) begin
              state_d = S_ERROR;
            end else if (len_q == DEPTH_IDX) begin
              state_d = S_DONE;
            end else begin
              // First fill word goes out with the checksum acceptance.
              state_d = S_FILL;
              we_d    = 1'b1;
              addr_d  = len_q[ADDR_W-1:0];
              wdata_d = '0;
              idx_d   = len_q + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (idx_q == DEPTH_IDX) begin
            state_d = S_DONE;
          end else begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_W-1:0];
            wdata_d = '0;
            idx_d   = idx_inc;
          end
        end
        S_DONE, S_ERROR: ;
        default: state_d = S_WAIT_SYNC;
      endcase

      if (in_frame && !rx_valid_i) begin
        if (tmo_inc == TMO_MAX) state_d = S_ERROR;
        else                    tmo_d   = tmo_inc;
      end
    end

    run_d  = (state_d == S_DONE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_SYNC;
      len_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      xor_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      xor_q   <= xor_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign cpu_run_o    = run_q;
  assign load_done_o  = done_q;
  assign load_error_o = err_q;

endmodule

// File: tb/tb_program_load_controller.sv
// Bench for program_load_controller: directed and random frames compared against
// a frame-level model of expected writes and flag timing.
`timescale 1ns/1ps
module tb_program_load_controller;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int          TMO    = 100;
  localparam logic [7:0]  SYNC   = 8'hA5;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] stamp;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic start = 1'b0;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0] mem_wdata;
  logic cpu_run, load_done, load_error;

  program_load_controller #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .start_i(start), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .cpu_run_o(cpu_run), .load_done_o(load_done),
    .load_error_o(load_error)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  // Write log and flag rise stamps, sampled mid-cycle.
  wr_t  wlog[$];
  int   done_rise = -1, err_rise = -1;
  logic done_p = 1'b0, err_p = 1'b0;
  always @(negedge clk) begin
    wr_t w;
    if (rst_n && mem_we) begin
      w.stamp = 32'(pcyc);
      w.addr  = 16'(mem_addr);
      w.data  = mem_wdata;
      wlog.push_back(w);
    end
    if (load_done && !done_p) done_rise = pcyc;
    if (load_error && !err_p) err_rise = pcyc;
    done_p = load_done;
    err_p  = load_error;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic wr_t mk_wr(input int stamp, input int addr, input logic [15:0] d);
    wr_t w;
    w.stamp = 32'(stamp);
    w.addr  = 16'(addr);
    w.data  = d;
    return w;
  endfunction

  task automatic send(input logic [7:0] b, input int gap, output int stamp);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    stamp    = pcyc;
    if (gap > 0) begin
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  // Frame-level model: expected writes, done-rise and error-rise stamps.
  task automatic expect_frame(input bq_t b, input int st[$], output wr_t ew[$],
                              output int edone, output int eerr);
    int i, len, hi_i, lo_i, c, n;
    logic [7:0] x;
    ew = {};
    edone = -1;
    eerr = -1;
    n = b.size();
    i = 0;
    while (i < n && b[i] != SYNC) i++;
    if (i == n) return;
    i++;
    if (i >= n) begin eerr = st[n-1] + 1 + TMO; return; end
    len = int'(b[i]);
    if (len == 0 || len > int'(DEPTH)) begin eerr = st[i] + 1; return; end
    x = 8'h00;
    for (int k = 0; k < len; k++) begin
      hi_i = i + 1 + 2 * k;
      lo_i = hi_i + 1;
      if (lo_i >= n) begin eerr = st[n-1] + 1 + TMO; return; end
      ew.push_back(mk_wr(st[lo_i] + 1, k, {b[hi_i], b[lo_i]}));
      x = x ^ b[hi_i] ^ b[lo_i];
    end
    c = i + 1 + 2 * len;
    if (c >= n) begin eerr = st[n-1] + 1 + TMO; return; end
    if (b[c] == x) begin
      for (int a = len; a < int'(DEPTH); a++) ew.push_back(mk_wr(st[c] + 1 + a - len, a, 16'h0000));
      edone = st[c] + 1 + int'(DEPTH) - len;
    end else begin
      eerr = st[c] + 1;
    end
  endtask

  task automatic do_frame(input string name, input bq_t b);
    int st[$];
    wr_t ew[$];
    wr_t got[$];
    int edone, eerr, fstart, s, gap, dr, er;
    fstart = pcyc;
    foreach (b[k]) begin
      gap = (k == b.size() - 1) ? 130 : int'($urandom_range(3, 0));
      send(b[k], gap, s);
      st.push_back(s);
    end
    expect_frame(b, st, ew, edone, eerr);
    foreach (wlog[k]) if (int'(wlog[k].stamp) >= fstart) got.push_back(wlog[k]);
    chk({name, " nwrites"}, 64'(got.size()), 64'(ew.size()));
    for (int k = 0; k < ew.size() && k < got.size(); k++)
      chk($sformatf("%s write%0d", name, k), got[k], ew[k]);
    dr = (done_rise >= fstart) ? done_rise : -1;
    er = (err_rise >= fstart) ? err_rise : -1;
    chk({name, " done_rise"}, 64'(dr), 64'(edone));
    chk({name, " err_rise"}, 64'(er), 64'(eerr));
    chk({name, " load_done"}, 64'(load_done), 64'(edone >= 0));
    chk({name, " cpu_run"}, 64'(cpu_run), 64'(edone >= 0));
    chk({name, " load_error"}, 64'(load_error), 64'(eerr >= 0));
  endtask

  task automatic pulse_start(input logic with_sync);
    @(negedge clk);
    start = 1'b1;
    if (with_sync) begin rx_valid = 1'b1; rx_data = SYNC; end
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b0;
    chk("start cpu_run", 64'(cpu_run), 64'(0));
    chk("start load_done", 64'(load_done), 64'(0));
    chk("start load_error", 64'(load_error), 64'(0));
  endtask

  function automatic bq_t mk_rand();
    bq_t f;
    int len, ng;
    logic [7:0] x, r;
    ng = int'($urandom_range(3, 0));
    for (int k = 0; k < ng; k++) begin
      do r = 8'($urandom_range(255, 0)); while (r == SYNC);
      f.push_back(r);
    end
    f.push_back(SYNC);
    if ($urandom_range(9, 0) == 0) begin
      len = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, 33));
      f.push_back(8'(len));
      return f;
    end
    len = int'($urandom_range(32, 1));
    f.push_back(8'(len));
    x = 8'h00;
    for (int k = 0; k < 2 * len; k++) begin
      r = 8'($urandom_range(255, 0));
      f.push_back(r);
      x = x ^ r;
    end
    if ($urandom_range(3, 0) == 0) x = x ^ 8'(1 << $urandom_range(7, 0));
    f.push_back(x);
    return f;
  endfunction

  initial begin
    bq_t f;
    logic [7:0] x, r;
    int s, rst_stamp, late;

    repeat (3) @(negedge clk);
    chk("reset mem_we", 64'(mem_we), 64'(0));
    chk("reset mem_addr", 64'(mem_addr), 64'(0));
    chk("reset mem_wdata", 64'(mem_wdata), 64'(0));
    chk("reset cpu_run", 64'(cpu_run), 64'(0));
    chk("reset load_done", 64'(load_done), 64'(0));
    chk("reset load_error", 64'(load_error), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    f = {8'hA5, 8'h02, 8'h40, 8'hAA, 8'h41, 8'h22, 8'h89};
    do_frame("good2", f);

    pulse_start(1'b0);
    f = {8'hA5, 8'h02, 8'h40, 8'hAA, 8'h41, 8'h22, 8'h88};
    do_frame("badcsum", f);

    pulse_start(1'b0);
    f = {8'h00, 8'hFF, 8'h13, 8'hA5, 8'h20};
    x = 8'h00;
    for (int k = 0; k < 64; k++) begin
      r = 8'($urandom_range(255, 0));
      f.push_back(r);
      x = x ^ r;
    end
    f.push_back(x);
    do_frame("full32", f);

    pulse_start(1'b0);
    f = {8'hA5, 8'h00};
    do_frame("len0", f);
    pulse_start(1'b0);
    f = {8'hA5, 8'h21};
    do_frame("len33", f);

    pulse_start(1'b0);
    f = {8'hA5, 8'h03, 8'h40};
    do_frame("timeout", f);

    pulse_start(1'b0);
    f = {8'hA5, 8'h01, 8'h12, 8'h34, 8'h26};
    do_frame("one", f);
    pulse_start(1'b1);
    do_frame("reload", f);

    for (int t = 0; t < 12; t++) begin
      pulse_start(1'b0);
      do_frame($sformatf("rand%0d", t), mk_rand());
    end

    // Reset in the middle of the zero-fill sweep.
    pulse_start(1'b0);
    send(8'hA5, 0, s);
    send(8'h01, 0, s);
    send(8'h12, 0, s);
    send(8'h34, 0, s);
    send(8'h26, 1, s);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    rst_stamp = pcyc;
    #1;
    chk("midfill reset mem_we", 64'(mem_we), 64'(0));
    chk("midfill reset mem_addr", 64'(mem_addr), 64'(0));
    chk("midfill reset load_done", 64'(load_done), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    late = 0;
    foreach (wlog[k]) if (int'(wlog[k].stamp) >= rst_stamp) late++;
    chk("midfill writes after reset", 64'(late), 64'(0));
    chk("midfill load_done", 64'(load_done), 64'(0));
    chk("midfill cpu_run", 64'(cpu_run), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
